// File: rtl/otter_fetch_stage_if.sv
// rtl/otter_fetch_stage_if.sv - fetch stage bus: I-cache port, stall/redirect controls, IF/ID register and counters
interface otter_fetch_stage_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      fetch_addr;
  logic [31:0]      mem_dout1;
  logic             pc_stall;
  logic             dcache_stall;
  logic             haz_stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             if_id_valid;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_pc4;
  logic [31:0]      if_id_instr;
  logic             misalign;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] istall_cnt;

  modport master (
    output fetch_addr,
    input  mem_dout1,
    input  pc_stall,
    input  dcache_stall,
    input  haz_stall,
    input  redirect,
    input  redirect_pc,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc4,
    output if_id_instr,
    output misalign,
    output instr_cnt,
    output istall_cnt
  );

  modport slave (
    input  fetch_addr,
    output mem_dout1,
    output pc_stall,
    output dcache_stall,
    output haz_stall,
    output redirect,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_instr,
    input  misalign,
    input  instr_cnt,
    input  istall_cnt
  );
endinterface

// File: rtl/otter_fetch_stage.sv
// rtl/otter_fetch_stage.sv - OTTER RV32I instruction fetch stage with PC, IF/ID register and perf counters
module otter_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst,
  otter_fetch_stage_if.master bus
);

  typedef enum logic {RUN, MISS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic             valid_q, valid_d;
  logic [31:0]      ifpc_q, ifpc_d;
  logic [31:0]      ifpc4_q, ifpc4_d;
  logic [31:0]      instr_q, instr_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      ifpc_q    <= 32'h0;
      ifpc4_q   <= 32'h0;
      instr_q   <= NOP;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
      mis_q     <= 1'b0;
      icnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      ifpc_q    <= ifpc_d;
      ifpc4_q   <= ifpc4_d;
      instr_q   <= instr_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      mis_q     <= mis_d;
      icnt_q    <= icnt_d;
      scnt_q    <= scnt_d;
    end
  end

  // The D-cache freeze holds the miss tracker along with the rest of the front end.
  always_comb begin
    state_d = state_q;
    if (!bus.dcache_stall) begin
      case (state_q)
        RUN:     if (bus.pc_stall)  state_d = MISS;
        MISS:    if (!bus.pc_stall) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    ifpc_d    = ifpc_q;
    ifpc4_d   = ifpc4_q;
    instr_d   = instr_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    mis_d     = mis_q;
    icnt_d    = icnt_q;
    scnt_d    = (bus.pc_stall && (scnt_q != CNT_MAX)) ? scnt_q + 1'b1 : scnt_q;

    if (bus.dcache_stall) begin
      if (bus.redirect) begin
        pend_d    = 1'b1;
        pend_pc_d = bus.redirect_pc;
      end
    end else if (bus.redirect && !bus.pc_stall) begin
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      mis_d   = mis_q | (|bus.redirect_pc[1:0]);
      valid_d = 1'b0;
      instr_d = NOP;
      pend_d  = 1'b0;
    end else if (bus.redirect) begin
      // PC must stay on the missing line so the refill completes against the right tag.
      pend_d    = 1'b1;
      pend_pc_d = bus.redirect_pc;
      valid_d   = 1'b0;
      instr_d   = NOP;
    end else if (pend_q && !bus.pc_stall) begin
      pc_d    = {pend_pc_q[31:2], 2'b00};
      mis_d   = mis_q | (|pend_pc_q[1:0]);
      valid_d = 1'b0;
      instr_d = NOP;
      pend_d  = 1'b0;
    end else if (bus.haz_stall) begin
      pc_d = pc_q;
    end else if (bus.pc_stall) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else begin
      valid_d = 1'b1;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      instr_d = bus.mem_dout1;
      pc_d    = pc_plus4;
      if (icnt_q != CNT_MAX) icnt_d = icnt_q + 1'b1;
    end
  end

  assign bus.fetch_addr  = pc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.if_id_pc4   = ifpc4_q;
  assign bus.if_id_instr = instr_q;
  assign bus.misalign    = mis_q;
  assign bus.instr_cnt   = icnt_q;
  assign bus.istall_cnt  = scnt_q;

endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb/tb_otter_fetch_stage.sv - directed and randomized bench for otter_fetch_stage against a cycle model
module tb_otter_fetch_stage;

  localparam int          CNT_W    = 6;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  otter_fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  otter_fetch_stage #(
    .RESET_PC(RESET_PC),
    .NOP     (NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always_comb bus.mem_dout1 = bus.pc_stall ? 32'hDEAD_BEEF : mem_word(bus.fetch_addr);

  // reference state
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_pend_pc;
  logic        m_valid, m_mis, m_pend;
  int          m_icnt, m_scnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 0; m_ifpc = 0; m_ifpc4 = 0; m_instr = NOP;
    m_mis = 0; m_icnt = 0; m_scnt = 0; m_pend = 0; m_pend_pc = 0;
  endtask

  task automatic model_jump(input logic [31:0] t);
    m_pc = t & 32'hFFFF_FFFC;
    if (t % 4 != 0) m_mis = 1;
  endtask

  task automatic model_flush();
    m_valid = 0;
    m_instr = NOP;
  endtask

  task automatic model_step(input bit ps, input bit dc, input bit hz, input bit rd,
                            input logic [31:0] rpc);
    if (ps && m_scnt < CMAX) m_scnt++;
    if (dc) begin
      if (rd) begin m_pend = 1; m_pend_pc = rpc; end
    end else if (rd && !ps) begin
      model_jump(rpc); model_flush(); m_pend = 0;
    end else if (rd) begin
      m_pend = 1; m_pend_pc = rpc; model_flush();
    end else if (m_pend && !ps) begin
      model_jump(m_pend_pc); model_flush(); m_pend = 0;
    end else if (hz) begin
      m_pend = m_pend;
    end else if (ps) begin
      model_flush();
    end else begin
      m_valid = 1; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = mem_word(m_pc);
      m_pc = m_pc + 32'd4;
      if (m_icnt < CMAX) m_icnt++;
    end
  endtask

  task automatic compare_all();
    check("fetch_addr", bus.fetch_addr, m_pc);
    check("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    check("if_id_pc", bus.if_id_pc, m_ifpc);
    check("if_id_pc4", bus.if_id_pc4, m_ifpc4);
    check("if_id_instr", bus.if_id_instr, m_instr);
    check("misalign", 32'(bus.misalign), 32'(m_mis));
    check("instr_cnt", 32'(bus.instr_cnt), 32'(m_icnt));
    check("istall_cnt", 32'(bus.istall_cnt), 32'(m_scnt));
  endtask

  // drive at negedge, model advances at posedge, compare at the next negedge
  task automatic step(input bit ps, input bit dc, input bit hz, input bit rd,
                      input logic [31:0] rpc);
    bus.pc_stall = ps; bus.dcache_stall = dc; bus.haz_stall = hz;
    bus.redirect = rd; bus.redirect_pc = rpc;
    @(posedge clk);
    model_step(ps, dc, hz, rd, rpc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hit();
    step(0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    bus.pc_stall = 0; bus.dcache_stall = 0; bus.haz_stall = 0;
    bus.redirect = 0; bus.redirect_pc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_instr_nop", bus.if_id_instr, 32'h0000_0013);
    rst = 0;

    // free run from reset
    for (int i = 0; i < 10; i++) begin
      hit();
      check("run_pc", bus.if_id_pc, 32'(i * 4));
      check("run_valid", 32'(bus.if_id_valid), 32'd1);
    end
    check("run_instr_cnt", 32'(bus.instr_cnt), 32'd10);

    // three-cycle miss at 0x40
    step(0, 0, 0, 1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 32'h0);
      check("miss_addr", bus.fetch_addr, 32'h40);
      check("miss_bubble", bus.if_id_instr, NOP);
    end
    check("miss_istall", 32'(bus.istall_cnt), 32'd3);
    hit();
    check("miss_done_pc", bus.if_id_pc, 32'h40);
    check("miss_done_valid", 32'(bus.if_id_valid), 32'd1);

    // redirect on a hit
    step(0, 0, 0, 1, 32'h20);
    hit();
    step(0, 0, 0, 1, 32'h100);
    check("redir_flush", bus.if_id_instr, NOP);
    check("redir_addr", bus.fetch_addr, 32'h100);
    hit();
    check("redir_pc", bus.if_id_pc, 32'h100);
    check("redir_instr", bus.if_id_instr, mem_word(32'h100));

    // redirect arriving mid-miss
    step(0, 0, 0, 1, 32'h80);
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h200);
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0);
    check("mmiss_hold", bus.fetch_addr, 32'h80);
    hit();
    check("mmiss_discard", 32'(bus.if_id_valid), 32'd0);
    check("mmiss_target", bus.fetch_addr, 32'h200);
    hit();
    check("mmiss_pc", bus.if_id_pc, 32'h200);

    // hazard vs redirect, hazard alone, freeze with redirect
    step(0, 0, 1, 1, 32'h180);
    check("haz_redir_flush", 32'(bus.if_id_valid), 32'd0);
    check("haz_redir_addr", bus.fetch_addr, 32'h180);
    hit();
    step(0, 0, 1, 0, 32'h0);
    step(0, 0, 1, 0, 32'h0);
    check("haz_hold_pc", bus.if_id_pc, 32'h180);
    check("haz_hold_addr", bus.fetch_addr, 32'h184);
    step(0, 1, 0, 1, 32'h300);
    step(0, 1, 0, 0, 32'h0);
    check("freeze_hold", bus.fetch_addr, 32'h184);
    hit();
    check("freeze_target", bus.fetch_addr, 32'h300);
    hit();
    check("freeze_pc", bus.if_id_pc, 32'h300);

    // PC wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFF8);
    hit();
    hit();
    check("wrap_pc4", bus.if_id_pc4, 32'h0);
    check("wrap_addr", bus.fetch_addr, 32'h0);

    // misaligned target
    step(0, 0, 0, 1, 32'h103);
    check("mis_addr", bus.fetch_addr, 32'h100);
    check("mis_flag", 32'(bus.misalign), 32'd1);
    repeat (3) hit();
    check("mis_sticky", 32'(bus.misalign), 32'd1);

    // saturation of both counters
    repeat (70) hit();
    check("instr_sat", 32'(bus.instr_cnt), 32'(CMAX));
    repeat (70) step(1, 0, 0, 0, 32'h0);
    check("istall_sat", 32'(bus.istall_cnt), 32'(CMAX));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit ps, dc, hz, rd;
      logic [31:0] rpc;
      ps  = ($urandom_range(0, 3) == 0);
      dc  = ($urandom_range(0, 9) == 0);
      hz  = ($urandom_range(0, 6) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'h0000_0FFF;
      step(ps, dc, hz, rd, rpc);
    end

    // asynchronous reset mid-miss with a pending redirect
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h444);
    #2 rst = 1;
    #1;
    check("arst_addr", bus.fetch_addr, RESET_PC);
    check("arst_valid", 32'(bus.if_id_valid), 32'd0);
    check("arst_instr", bus.if_id_instr, NOP);
    check("arst_mis", 32'(bus.misalign), 32'd0);
    check("arst_icnt", 32'(bus.instr_cnt), 32'd0);
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 0;
    hit();
    check("arst_run_pc", bus.if_id_pc, RESET_PC);
    check("arst_run_addr", bus.fetch_addr, RESET_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
